enc_rr_prio: RTL and testbench
==============================

// Module: enc_rr_prio
// PURPOSE
//  Parametrised, registered N-to-log2(N) encoder. It is the clocked successor to the
//  gate-level 8x3 encoder. It resolves any number of active inputs through either
//  fixed priority or round-robin priority, and reports a multi-hot flag, a zero flag
//  and a popcount. It sits between request sources and a consumer, with a
//  valid/ready handshake on both sides and a one-entry output register.
// PARAMETERS
//  N     8           number of input lines, N >= 2; N need not be a power of two
//  W     $clog2(N)   width of the encoded index y
//  CW    $clog2(N+1) width of the popcount output cnt
//  MODE  0           0 = fixed priority, highest set index wins
//                    1 = round-robin, search starts at ptr and wraps
// PORTS
//  clk        in   1    clock; all state updates on the rising edge
//  rst        in   1    synchronous reset, active-high
//  in_valid   in   1    the d vector is presented
//  in_ready   out  1    the block can accept d this cycle
//  d          in   N    one-hot or multi-hot input lines
//  out_valid  out  1    y, none, multi and cnt hold a result
//  out_ready  in   1    the consumer takes the result this cycle
//  y          out  W    index of the winning line
//  none       out  1    the accepted d was all zeros
//  multi      out  1    more than one bit of the accepted d was set
//  cnt        out  CW   number of set bits in the accepted d
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - out_valid=0, y=0, none=0, multi=0, cnt=0, ptr=0.
//   - in_ready is forced to 0 while rst is high.
//   - A pending result is discarded.
//  Handshake:
//   - in_ready = !rst && (!out_valid || out_ready). It is combinational; no combinational
//     path exists from in_valid or d to in_ready.
//   - accept = in_valid && in_ready. On accept, the next edge loads y/none/multi/cnt and
//     sets out_valid=1. Latency is 1 cycle; full throughput is 1 result per cycle.
//   - Result hold: while out_valid && !out_ready, y/none/multi/cnt/out_valid stay stable
//     and d is ignored.
//   - Simultaneous events: if out_ready and a new accept occur in the same cycle, the
//     old result drains and the new one is loaded at the same edge; out_valid stays 1.
//   - Drain: if out_ready=1 and there is no accept, out_valid falls to 0 at the next edge.
//     y and the flags keep their last values.
//  Encoding (applied to the d sampled at accept):
//   - MODE 0: y = highest index i with d[i]=1. ptr stays 0.
//   - MODE 1: y = first set index in the order ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   - MODE 1 pointer update: after a grant at g, ptr <= (g==N-1) ? 0 : g+1.
//     ptr never takes a value >= N, including when N is not a power of two.
//   - Zero input: d==0 gives none=1, y=0, multi=0, cnt=0. ptr is not updated.
//   - multi = (cnt > 1). cnt is an exact popcount with no overflow, since CW holds N.
//  Other rules:
//   - ptr advances only on an accepted, non-zero d. It does not advance on a stall or
//     while a result is held.
//   - Reset mid-operation: the held result is lost and ptr returns to 0. The first
//     accept after reset is evaluated from ptr=0.
// TESTING
//  T1 (N=8, MODE=0):
//   - d=00001100 accepted at cycle k -> at k+1: out_valid=1, y=3, multi=1, cnt=2, none=0.
//   - Each one-hot d from bit0 to bit7 -> y=0..7, multi=0, cnt=1.
//  T2 (N=8, MODE=1):
//   - d=11111111 held with in_valid=1 and out_ready=1 for 9 cycles -> y sequence
//     0,1,2,3,4,5,6,7,0. cnt=8 and multi=1 every cycle.
//  T3 (N=8, MODE=1):
//   - ptr=5, d=00100010 -> y=5 and ptr becomes 6.
//   - The next d=00100010 -> y=1 (wrap) and ptr becomes 2.
//  T4 (backpressure):
//   - out_ready=0 for 3 cycles with a result held -> in_ready=0 and the outputs are
//     unchanged. A new d offered during the stall is not taken and ptr does not move.
//   - On out_ready=1 -> the held result drains and the new d is accepted the same cycle.
//  T5 (zero vector and reset):
//   - d=00000000 -> none=1, y=0, cnt=0, ptr unchanged.
//   - rst=1 for 1 cycle while out_valid=1 -> the next cycle shows out_valid=0, ptr=0,
//     cnt=0 and in_ready=0 during the reset cycle.
//  T6 (N=5, MODE=1):
//   - d=10001 twice -> y=0, then y=4. The third d=10001 gives y=0 (ptr wraps 4->0),
//     and ptr is never >= 5.

Source files
------------

// File: rtl/enc_rr_prio_if.sv
// Request/result bus for enc_rr_prio: valid/ready on the input side,
// valid/ready on the result side.
interface enc_rr_prio_if #(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter int CW = $clog2(N + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  d;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          none;
  logic          multi;
  logic [CW-1:0] cnt;

  // request source and result consumer
  modport master (
    output in_valid, d, out_ready,
    input  in_ready, out_valid, y, none, multi, cnt
  );

  // the encoder
  modport slave (
    input  in_valid, d, out_ready,
    output in_ready, out_valid, y, none, multi, cnt
  );
endinterface

// File: rtl/enc_rr_prio.sv
// Registered N-to-log2(N) priority encoder with a one-entry result register.
// MODE 0 picks the highest set line; MODE 1 picks round-robin starting at ptr.
// Also reports zero/multi-hot flags and an exact popcount of the accepted vector.
module enc_rr_prio #(
  parameter int N    = 8,
  parameter int MODE = 0,
  parameter int W    = $clog2(N),
  parameter int CW   = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         rst,
  enc_rr_prio_if.slave bus
);

  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  y_q, y_d;
  logic          none_q, none_d;
  logic          multi_q, multi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  ptr_q, ptr_d;

  logic          in_ready;
  logic          accept;
  logic [CW-1:0] pop_c;
  logic [W-1:0]  fix_idx;
  logic [W-1:0]  rr_idx;
  logic          rr_found;
  logic [W-1:0]  win_idx;
  int            ptr_nxt;

  // ready depends only on reset and the result register, never on in_valid/d
  assign in_ready = !rst && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // popcount and both priority searches over the presented vector
  always_comb begin
    pop_c    = '0;
    fix_idx  = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      pop_c = pop_c + {{(CW-1){1'b0}}, bus.d[i]};
      if (bus.d[i]) fix_idx = i[W-1:0];
    end
    // first pass: lines at or above ptr; second pass: wrap to the lowest line
    for (int i = 0; i < N; i++) begin
      if (!rr_found && bus.d[i] && (i >= int'(ptr_q))) begin
        rr_idx   = i[W-1:0];
        rr_found = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (!rr_found && bus.d[i]) rr_idx = i[W-1:0];
    end
    win_idx = (MODE == 1) ? rr_idx : fix_idx;
    // explicit wrap keeps ptr below N for non-power-of-two N
    ptr_nxt = (int'(win_idx) == N - 1) ? 0 : int'(win_idx) + 1;
  end

  // next-state for the result register and the round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    none_d      = none_q;
    multi_d     = multi_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      cnt_d       = pop_c;
      none_d      = (pop_c == '0);
      multi_d     = (pop_c > {{(CW-1){1'b0}}, 1'b1});
      y_d         = (pop_c == '0) ? '0 : win_idx;
      if ((MODE == 1) && (pop_c != '0)) ptr_d = ptr_nxt[W-1:0];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // state registers with synchronous reset; a pending result is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      none_q      <= 1'b0;
      multi_q     <= 1'b0;
      cnt_q       <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      none_q      <= none_d;
      multi_q     <= multi_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.none      = none_q;
  assign bus.multi     = multi_q;
  assign bus.cnt       = cnt_q;

endmodule

// File: tb/tb_enc_rr_prio.sv
// Bench for enc_rr_prio: three instances (N=8 fixed, N=8 round-robin,
// N=5 round-robin) share one directed stimulus stream. A behavioural model
// predicts every output each cycle; literal checks pin the key scenarios.
module tb_enc_rr_prio;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] d8;
  logic       chk_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  enc_rr_prio_if #(.N(8)) if_m0 ();
  enc_rr_prio_if #(.N(8)) if_r8 ();
  enc_rr_prio_if #(.N(5)) if_n5 ();

  assign if_m0.in_valid  = in_valid;
  assign if_m0.out_ready = out_ready;
  assign if_m0.d         = d8;
  assign if_r8.in_valid  = in_valid;
  assign if_r8.out_ready = out_ready;
  assign if_r8.d         = d8;
  assign if_n5.in_valid  = in_valid;
  assign if_n5.out_ready = out_ready;
  assign if_n5.d         = d8[4:0];

  enc_rr_prio #(.N(8), .MODE(0)) u_m0 (.clk(clk), .rst(rst), .bus(if_m0.slave));
  enc_rr_prio #(.N(8), .MODE(1)) u_r8 (.clk(clk), .rst(rst), .bus(if_r8.slave));
  enc_rr_prio #(.N(5), .MODE(1)) u_n5 (.clk(clk), .rst(rst), .bus(if_n5.slave));

  // model parameters and state, index 0 = m0, 1 = r8, 2 = n5
  int nn[3] = '{8, 8, 5};
  int mm[3] = '{0, 1, 1};
  int m_ov[3], m_y[3], m_none[3], m_multi[3], m_cnt[3], m_ptr[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: registered result, priority chosen by scanning the vector
  always @(posedge clk) begin
    logic [7:0] dm;
    int c, g;
    bit found;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_ov[i] = 0; m_y[i] = 0; m_none[i] = 0; m_multi[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
      end else if (in_valid && (m_ov[i] == 0 || out_ready)) begin
        dm = (nn[i] == 5) ? {3'b000, d8[4:0]} : d8;
        c = $countones(dm);
        m_ov[i] = 1;
        m_cnt[i] = c;
        m_none[i] = (c == 0);
        m_multi[i] = (c > 1);
        if (c == 0) begin
          m_y[i] = 0;
        end else begin
          found = 0;
          g = 0;
          if (mm[i] == 0) begin
            for (int j = nn[i] - 1; j >= 0; j--)
              if (!found && dm[j]) begin g = j; found = 1; end
          end else begin
            for (int k = 0; k < nn[i]; k++)
              if (!found && dm[(m_ptr[i] + k) % nn[i]]) begin g = (m_ptr[i] + k) % nn[i]; found = 1; end
            m_ptr[i] = (g + 1) % nn[i];
          end
          m_y[i] = g;
        end
      end else if (out_ready) begin
        m_ov[i] = 0;
      end
    end
  end

  task automatic cmp(input int i, input logic ov, input logic ir, input int y,
                     input logic none, input logic multi, input int cnt, input int ptr);
    logic exp_ir;
    exp_ir = !rst && (m_ov[i] == 0 || out_ready);
    chk($sformatf("inst%0d out_valid", i), 32'(ov), 32'(m_ov[i]));
    chk($sformatf("inst%0d in_ready", i), 32'(ir), 32'(exp_ir));
    chk($sformatf("inst%0d y", i), 32'(y), 32'(m_y[i]));
    chk($sformatf("inst%0d none", i), 32'(none), 32'(m_none[i]));
    chk($sformatf("inst%0d multi", i), 32'(multi), 32'(m_multi[i]));
    chk($sformatf("inst%0d cnt", i), 32'(cnt), 32'(m_cnt[i]));
    chk($sformatf("inst%0d ptr", i), 32'(ptr), 32'(m_ptr[i]));
  endtask

  // compare process: outputs settle well before the falling edge
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      cmp(0, if_m0.out_valid, if_m0.in_ready, int'(if_m0.y), if_m0.none, if_m0.multi,
          int'(if_m0.cnt), int'(u_m0.ptr_q));
      cmp(1, if_r8.out_valid, if_r8.in_ready, int'(if_r8.y), if_r8.none, if_r8.multi,
          int'(if_r8.cnt), int'(u_r8.ptr_q));
      cmp(2, if_n5.out_valid, if_n5.in_ready, int'(if_n5.y), if_n5.none, if_n5.multi,
          int'(if_n5.cnt), int'(u_n5.ptr_q));
    end
  end

  task automatic step(input logic r, input logic iv, input logic o, input logic [7:0] dv);
    @(negedge clk);
    rst = r; in_valid = iv; out_ready = o; d8 = dv;
  endtask

  task automatic after_edge;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] oh;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; d8 = '0;

    // reset
    step(1, 0, 1, 8'h00); after_edge;
    chk_en = 1'b1;
    step(1, 0, 1, 8'h00);
    #1 chk("rst in_ready", 32'(if_r8.in_ready), 32'd0);
    after_edge;
    chk("rst out_valid", 32'(if_m0.out_valid), 32'd0);
    chk("rst cnt", 32'(if_m0.cnt), 32'd0);

    // T1: fixed priority, multi-hot then every one-hot
    step(0, 1, 1, 8'b0000_1100); after_edge;
    chk("t1 out_valid", 32'(if_m0.out_valid), 32'd1);
    chk("t1 y", 32'(if_m0.y), 32'd3);
    chk("t1 multi", 32'(if_m0.multi), 32'd1);
    chk("t1 cnt", 32'(if_m0.cnt), 32'd2);
    chk("t1 none", 32'(if_m0.none), 32'd0);
    chk("t1 rr y", 32'(if_r8.y), 32'd2);
    for (int i = 0; i < 8; i++) begin
      oh = 8'h01 << i;
      step(0, 1, 1, oh); after_edge;
      chk($sformatf("t1 onehot%0d y", i), 32'(if_m0.y), 32'(i));
      chk($sformatf("t1 onehot%0d cnt", i), 32'(if_m0.cnt), 32'd1);
      chk($sformatf("t1 onehot%0d multi", i), 32'(if_m0.multi), 32'd0);
    end

    // T2: all ones, round-robin walks 0..7 and wraps
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 1, 8'hFF); after_edge;
      chk($sformatf("t2 y%0d", k), 32'(if_r8.y), 32'(k % 8));
      chk($sformatf("t2 cnt%0d", k), 32'(if_r8.cnt), 32'd8);
      chk($sformatf("t2 multi%0d", k), 32'(if_r8.multi), 32'd1);
    end

    // T3: park ptr at 5, then grant 5 and wrap to 1
    step(0, 1, 1, 8'h10); after_edge;
    chk("t3 ptr5", 32'(u_r8.ptr_q), 32'd5);
    step(0, 1, 1, 8'b0010_0010); after_edge;
    chk("t3 y5", 32'(if_r8.y), 32'd5);
    chk("t3 ptr6", 32'(u_r8.ptr_q), 32'd6);
    chk("t3 fixed y", 32'(if_m0.y), 32'd5);
    step(0, 1, 1, 8'b0010_0010); after_edge;
    chk("t3 y wrap", 32'(if_r8.y), 32'd1);
    chk("t3 ptr2", 32'(u_r8.ptr_q), 32'd2);

    // T4: stall for three cycles, then drain and accept together
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 8'h80); after_edge;
      chk("t4 hold y", 32'(if_r8.y), 32'd1);
      chk("t4 hold valid", 32'(if_r8.out_valid), 32'd1);
      chk("t4 in_ready", 32'(if_r8.in_ready), 32'd0);
      chk("t4 ptr", 32'(u_r8.ptr_q), 32'd2);
    end
    step(0, 1, 1, 8'h80);
    #1 chk("t4 release in_ready", 32'(if_r8.in_ready), 32'd1);
    after_edge;
    chk("t4 new y", 32'(if_r8.y), 32'd7);
    chk("t4 valid", 32'(if_r8.out_valid), 32'd1);

    // T5: zero vector keeps ptr, drain, reset while holding a result
    step(0, 1, 1, 8'h00); after_edge;
    chk("t5 none", 32'(if_r8.none), 32'd1);
    chk("t5 y", 32'(if_r8.y), 32'd0);
    chk("t5 cnt", 32'(if_r8.cnt), 32'd0);
    step(0, 0, 1, 8'h00); after_edge;
    chk("t5 drain valid", 32'(if_r8.out_valid), 32'd0);
    chk("t5 drain none kept", 32'(if_r8.none), 32'd1);
    step(0, 1, 1, 8'h81); after_edge;
    chk("t5 ptr kept y", 32'(if_r8.y), 32'd0);
    chk("t5 fixed y", 32'(if_m0.y), 32'd7);
    step(1, 1, 1, 8'hFF);
    #1 chk("t5 rst in_ready", 32'(if_r8.in_ready), 32'd0);
    after_edge;
    chk("t5 rst valid", 32'(if_r8.out_valid), 32'd0);
    chk("t5 rst cnt", 32'(if_r8.cnt), 32'd0);
    chk("t5 rst ptr", 32'(u_r8.ptr_q), 32'd0);
    step(0, 1, 1, 8'h81); after_edge;
    chk("t5 post rst y", 32'(if_r8.y), 32'd0);

    // T6: N=5 round-robin wraps 4 -> 0
    step(1, 0, 1, 8'h00); after_edge;
    step(0, 1, 1, 8'h11); after_edge;
    chk("t6 y0", 32'(if_n5.y), 32'd0);
    step(0, 1, 1, 8'h11); after_edge;
    chk("t6 y4", 32'(if_n5.y), 32'd4);
    chk("t6 ptr wrap", 32'(u_n5.ptr_q), 32'd0);
    step(0, 1, 1, 8'h11); after_edge;
    chk("t6 y0 again", 32'(if_n5.y), 32'd0);
    chk("t6 ptr1", 32'(u_n5.ptr_q), 32'd1);

    step(0, 0, 1, 8'h00); after_edge;
    step(0, 0, 1, 8'h00); after_edge;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
